// File: rtl/uart8n1_tx_drain.sv
// UART 8N1 transmitter that drains a byte FIFO through its falling-edge read strobe.
// Optional `UART_TX_CTS_EN adds a synchronised active-low clear-to-send input cts_n.
module uart8n1_tx_drain #(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_odat,
`ifdef UART_TX_CTS_EN
  input  logic       cts_n,
`endif
  output logic       fifo_oen,
  output logic       txd,
  output logic       busy,
  output logic       tx_done
);

  localparam int unsigned BAUD_DIV  = (CLK_HZ / BAUD < 2) ? 2 : CLK_HZ / BAUD;
  localparam int unsigned CW        = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {IDLE, REQ, DROP, LOAD, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] baud, baud_n;
  logic [2:0]    bitc, bitc_n;
  logic [7:0]    shift, shift_n;
  logic          txd_n, oen_n, busy_n, done_n;
  logic          cts_ok;
  logic          baud_wrap;

`ifdef UART_TX_CTS_EN
  logic [1:0] cts_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cts_sync <= '1;
    else     cts_sync <= {cts_sync[0], cts_n};
  end

  assign cts_ok = ~cts_sync[1];
`else
  assign cts_ok = 1'b1;
`endif

  assign baud_wrap = (baud == BAUD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud     <= '0;
      bitc     <= '0;
      shift    <= '0;
      txd      <= 1'b1;
      fifo_oen <= 1'b0;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_n;
      baud     <= baud_n;
      bitc     <= bitc_n;
      shift    <= shift_n;
      txd      <= txd_n;
      fifo_oen <= oen_n;
      busy     <= busy_n;
      tx_done  <= done_n;
    end
  end

  // fifo_oen and tx_done default low, so each can only ever be a single-cycle pulse.
  always_comb begin
    state_n = state;
    baud_n  = baud;
    bitc_n  = bitc;
    shift_n = shift;
    txd_n   = txd;
    oen_n   = 1'b0;
    busy_n  = busy;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (tx_en && fifo_empty && cts_ok) begin
          state_n = REQ;
          oen_n   = 1'b1;
          busy_n  = 1'b1;
        end
      end
      REQ:  state_n = DROP;
      DROP: state_n = LOAD;
      LOAD: begin
        shift_n = fifo_odat;
        txd_n   = 1'b0;
        baud_n  = '0;
        bitc_n  = '0;
        state_n = START;
      end
      START: begin
        if (baud_wrap) begin
          baud_n  = '0;
          bitc_n  = '0;
          txd_n   = shift[0];
          shift_n = {1'b0, shift[7:1]};
          state_n = DATA;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      DATA: begin
        if (baud_wrap) begin
          baud_n = '0;
          if (bitc == 3'd7) begin
            txd_n   = 1'b1;
            state_n = STOP;
          end else begin
            txd_n   = shift[0];
            shift_n = {1'b0, shift[7:1]};
            bitc_n  = bitc + 3'd1;
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      STOP: begin
        if (baud_wrap) begin
          baud_n  = '0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart8n1_tx_drain.sv
// Bench for uart8n1_tx_drain: FIFO model with falling-edge pop, frame decoder and
// expected-byte scoreboard; BAUD_DIV = 16.
module tb_uart8n1_tx_drain;

  logic       clk = 1'b0;
  logic       rst, tx_en, fifo_empty;
  logic [7:0] fifo_odat;
  logic       fifo_oen, txd, busy, tx_done;
`ifdef UART_TX_CTS_EN
  logic       cts_n;
`endif

  uart8n1_tx_drain #(.CLK_HZ(1600), .BAUD(100)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_en      (tx_en),
    .fifo_empty (fifo_empty),
    .fifo_odat  (fifo_odat),
`ifdef UART_TX_CTS_EN
    .cts_n      (cts_n),
`endif
    .fifo_oen   (fifo_oen),
    .txd        (txd),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  int nchk = 0, nerr = 0;
  int cyc = 0, pops = 0, frames = 0, fcnt = 0, last_end = 0, grp_base = 0, shape_err = 0;
  bit in_frame = 0, btb = 0, oen_prev = 0, txd_prev = 1, pop_pend = 0;
  logic [7:0] got_b, exp_b;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input logic [7:0] b, input bit expect_sent);
    fifo_q.push_back(b);
    if (expect_sent) exp_q.push_back(b);
    fifo_empty = 1'b1;
  endtask

  // One clock plus FIFO model and frame monitor; sampled 1 time unit after the edge.
  task automatic step();
    logic e;
    @(posedge clk);
    #1;
    cyc++;
    if (pop_pend) begin
      pop_pend = 0;
      if (fifo_q.size() > 0) fifo_odat = fifo_q.pop_front();
      fifo_empty = (fifo_q.size() != 0);
    end
    if (fifo_oen) check("oen_width", 32'(oen_prev), 0);
    if (oen_prev && !fifo_oen) begin
      pops++;
      pop_pend = 1;
    end
    oen_prev = fifo_oen;
    if (!in_frame && txd_prev && !txd) begin
      in_frame  = 1;
      fcnt      = 0;
      shape_err = 0;
      got_b     = '0;
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 1, 0);
        exp_b = '0;
      end else begin
        exp_b = exp_q[0];
      end
      if (btb && frames > grp_base) check("gap", 32'(cyc - last_end), 4);
    end
    if (in_frame) begin
      if (fcnt < 160) begin
        if (fcnt >= 16 && fcnt < 144 && fcnt % 16 == 8) got_b[(fcnt - 16) / 16] = txd;
        e = (fcnt < 16) ? 1'b0 : (fcnt < 144) ? exp_b[(fcnt - 16) / 16] : 1'b1;
        if (txd !== e || busy !== 1'b1 || tx_done !== 1'b0) shape_err++;
      end else if (fcnt == 160) begin
        check("frame_byte", 32'(got_b), 32'(exp_b));
        check("frame_shape", 32'(shape_err), 0);
        check("tx_done", 32'(tx_done), 1);
        check("busy_end", 32'(busy), 0);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        frames++;
        last_end = cyc;
      end else begin
        check("done_width", 32'(tx_done), 0);
        in_frame = 0;
      end
      fcnt++;
    end
    txd_prev = txd;
  endtask

  task automatic run_frames(input int n, input int max);
    int t = 0;
    while (!(frames >= n && !in_frame) && t < max) begin
      step();
      t++;
    end
    check("frame_wait", 32'(t < max), 1);
  endtask

  task automatic run_to_bit(input int fc, input int max);
    int t = 0;
    while (!(in_frame && fcnt == fc) && t < max) begin
      step();
      t++;
    end
    check("bit_wait", 32'(t < max), 1);
  endtask

  initial begin
    int o, l, b, p0, f0;
    rst = 1'b1; tx_en = 1'b1; fifo_empty = 1'b0; fifo_odat = 8'h00;
`ifdef UART_TX_CTS_EN
    cts_n = 1'b0;
`endif
    repeat (3) step();
    check("rst_txd", 32'(txd), 1);
    check("rst_oen", 32'(fifo_oen), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(tx_done), 0);
    rst = 1'b0;

    // No data available: line stays idle.
    o = 0; l = 0; b = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (fifo_oen) o++;
      if (!txd) l++;
      if (busy) b++;
    end
    check("idle_oen", 32'(o), 0);
    check("idle_txd_low", 32'(l), 0);
    check("idle_busy", 32'(b), 0);

    // Single byte.
    p0 = pops;
    push(8'hA5, 1);
    run_frames(1, 400);
    check("pops_single", 32'(pops - p0), 1);

    // Back-to-back frames.
    p0 = pops; grp_base = frames; btb = 1;
    push(8'h00, 1); push(8'hFF, 1); push(8'h55, 1);
    run_frames(frames + 3, 800);
    check("pops_three", 32'(pops - p0), 3);
    repeat (10) step();
    btb = 0;

    // tx_en dropped during data bit 3: frame completes, nothing more popped.
    p0 = pops; f0 = frames;
    push(8'h3C, 1); push(8'h77, 0);
    run_to_bit(16 * 4 + 4, 400);
    tx_en = 1'b0;
    run_frames(f0 + 1, 400);
    repeat (60) step();
    check("txen_pops", 32'(pops - p0), 1);
    check("txen_frames", 32'(frames - f0), 1);
    check("txen_busy", 32'(busy), 0);
    check("txen_left", 32'(fifo_q.size()), 1);

    // Reset during data bit 5 of 0x77: frame aborted, next byte follows.
    exp_q.push_back(8'h77);
    push(8'hC3, 1);
    p0 = pops; f0 = frames;
    tx_en = 1'b1;
    run_to_bit(16 * 6 + 6, 400);
    rst = 1'b1;
    #1;
    check("rstmid_txd", 32'(txd), 1);
    check("rstmid_busy", 32'(busy), 0);
    in_frame = 0;
    void'(exp_q.pop_front());
    repeat (2) step();
    rst = 1'b0;
    run_frames(f0 + 1, 400);
    check("rstmid_pops", 32'(pops - p0), 2);
    check("rstmid_fifo_empty", 32'(fifo_empty), 0);

`ifdef UART_TX_CTS_EN
    // Flow control: held off while cts_n is high, then a prompt pop.
    cts_n = 1'b1;
    repeat (5) step();
    p0 = pops;
    push(8'h96, 1);
    repeat (50) step();
    check("cts_hold_pops", 32'(pops - p0), 0);
    cts_n = 1'b0;
    o = 0;
    while (!fifo_oen && o < 10) begin
      step();
      o++;
    end
    check("cts_latency_ok", 32'(o <= 3), 1);
    run_frames(frames + 1, 400);
    check("cts_pops", 32'(pops - p0), 1);
`endif

    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
